// File: rtl/pkt_keep_gen.sv
// ============================================================================
//  Module      : pkt_keep_gen
//  Description : Turns a packet byte length into a sequence of beats with
//                thermometer keep masks and first/last markers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_keep_gen #(
    parameter int KEEP_W = 4,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              len_valid_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              len_ready_o,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              first_o,
    output logic              last_o
);

    localparam logic [LEN_W-1:0] c_keep_w = LEN_W'(KEEP_W);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_rem;
    logic [LEN_W-1:0]   w_rem_nxt;
    logic [KEEP_W-1:0]  r_keep;
    logic [KEEP_W-1:0]  w_keep_nxt;
    logic               r_first;
    logic               w_first_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic               w_beat_acc;
    logic               w_req_acc;

    // Byte i is covered when more than i bytes remain.
    function automatic logic [KEEP_W-1:0] keep_of(input logic [LEN_W-1:0] rem);
        logic [KEEP_W-1:0] k;
        k = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            k[i] = (rem > LEN_W'(i));
        end
        return k;
    endfunction

    assign valid_o     = (r_state == ST_SEND);
    assign keep_o      = r_keep;
    assign first_o     = r_first;
    assign last_o      = r_last;
    assign w_beat_acc  = valid_o && ready_i;
    assign len_ready_o = !rst && ((r_state == ST_IDLE) || (w_beat_acc && r_last));
    assign w_req_acc   = len_valid_i && len_ready_o;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_keep_nxt  = r_keep;
        w_first_nxt = r_first;
        w_last_nxt  = r_last;

        if (w_req_acc && (len_i != '0)) begin
            // New packet; also covers the zero-bubble handover after a last beat.
            w_state_nxt = ST_SEND;
            w_rem_nxt   = len_i;
            w_keep_nxt  = keep_of(len_i);
            w_first_nxt = 1'b1;
            w_last_nxt  = (len_i <= c_keep_w);
        end else if (w_beat_acc) begin
            if (r_last) begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = '0;
                w_keep_nxt  = '0;
                w_first_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end else begin
                // Not last implies rem > KEEP_W, so this cannot wrap.
                w_rem_nxt   = r_rem - c_keep_w;
                w_keep_nxt  = keep_of(r_rem - c_keep_w);
                w_first_nxt = 1'b0;
                w_last_nxt  = ((r_rem - c_keep_w) <= c_keep_w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_keep  <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_keep  <= w_keep_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pkt_keep_gen.sv
// ============================================================================
//  Module      : tb_pkt_keep_gen
//  Description : Directed self-checking bench for pkt_keep_gen (KEEP_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_keep_gen;

    localparam int KEEP_W = 4;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              rst;
    logic              len_valid_i;
    logic [LEN_W-1:0]  len_i;
    logic              len_ready_o;
    logic              ready_i;
    logic              valid_o;
    logic [KEEP_W-1:0] keep_o;
    logic              first_o;
    logic              last_o;

    int n_cmp;
    int n_err;
    int n_beats;
    int n_bytes;

    pkt_keep_gen #(
        .KEEP_W (KEEP_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .len_valid_i (len_valid_i),
        .len_i       (len_i),
        .len_ready_o (len_ready_o),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .keep_o      (keep_o),
        .first_o     (first_o),
        .last_o      (last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs mid-cycle, then let combinational outputs settle.
    task automatic step(input logic r, input logic lv, input logic [LEN_W-1:0] len, input logic rdy);
        @(negedge clk);
        rst         = r;
        len_valid_i = lv;
        len_i       = len;
        ready_i     = rdy;
        #1;
    endtask

    task automatic beat(input string tag, input logic [3:0] k, input logic f, input logic l);
        chk({tag, ".valid"}, 32'(valid_o), 32'd1);
        chk({tag, ".keep"},  32'(keep_o),  32'(k));
        chk({tag, ".first"}, 32'(first_o), 32'(f));
        chk({tag, ".last"},  32'(last_o),  32'(l));
        if (valid_o && ready_i) begin
            n_beats++;
            n_bytes += $countones(keep_o);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; len_valid_i = 1'b0; len_i = '0; ready_i = 1'b0;

        // Reset state
        step(1'b1, 1'b1, 16'd5, 1'b1);
        step(1'b1, 1'b1, 16'd5, 1'b1);
        chk("rst.len_ready", 32'(len_ready_o), 32'd0);
        chk("rst.valid",     32'(valid_o),     32'd0);
        chk("rst.keep",      32'(keep_o),      32'd0);
        chk("rst.first",     32'(first_o),     32'd0);
        chk("rst.last",      32'(last_o),      32'd0);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("idle.len_ready", 32'(len_ready_o), 32'd1);

        // len=10 with continuous ready
        step(1'b0, 1'b1, 16'd10, 1'b1);
        chk("l10.acc", 32'(len_ready_o), 32'd1);
        chk("l10.v0",  32'(valid_o),     32'd0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l10.b1", 4'b1111, 1'b1, 1'b0);
        chk("l10.busy", 32'(len_ready_o), 32'd0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l10.b2", 4'b1111, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l10.b3", 4'b0011, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("l10.end", 32'(valid_o), 32'd0);

        // len=8: exact multiple
        step(1'b0, 1'b1, 16'd8, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l8.b1", 4'b1111, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l8.b2", 4'b1111, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("l8.end", 32'(valid_o), 32'd0);

        // len=1
        step(1'b0, 1'b1, 16'd1, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l1.b1", 4'b0001, 1'b1, 1'b1);

        // len=0 consumed without a beat, next request accepted right after
        step(1'b0, 1'b1, 16'd0, 1'b1);
        chk("l0.acc", 32'(len_ready_o), 32'd1);
        step(1'b0, 1'b1, 16'd1, 1'b1);
        chk("l0.novalid", 32'(valid_o),     32'd0);
        chk("l0.next_acc", 32'(len_ready_o), 32'd1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("l0.nb", 4'b0001, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("l0.end", 32'(valid_o), 32'd0);

        // len=10 with backpressure on beat 2
        n_beats = 0; n_bytes = 0;
        step(1'b0, 1'b1, 16'd10, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("bp.b1",  4'b1111, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0); beat("bp.h1",  4'b1111, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0); beat("bp.h2",  4'b1111, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0); beat("bp.h3",  4'b1111, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("bp.b2",  4'b1111, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("bp.b3",  4'b0011, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("bp.end",   32'(valid_o), 32'd0);
        chk("bp.beats", 32'(n_beats), 32'd3);
        chk("bp.bytes", 32'(n_bytes), 32'd10);

        // Back-to-back 3 then 5
        step(1'b0, 1'b1, 16'd3, 1'b1);
        chk("b2b.accA", 32'(len_ready_o), 32'd1);
        step(1'b0, 1'b1, 16'd5, 1'b1); beat("b2b.a1", 4'b0111, 1'b1, 1'b1);
        chk("b2b.accB", 32'(len_ready_o), 32'd1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("b2b.b1", 4'b1111, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("b2b.b2", 4'b0001, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("b2b.end", 32'(valid_o), 32'd0);

        // Reset mid-packet
        step(1'b0, 1'b1, 16'd12, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("mr.b1", 4'b1111, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'd0, 1'b1); beat("mr.b2", 4'b1111, 1'b0, 1'b0);
        chk("mr.rdy_rst", 32'(len_ready_o), 32'd0);
        step(1'b0, 1'b1, 16'd4, 1'b1);
        chk("mr.valid", 32'(valid_o),     32'd0);
        chk("mr.keep",  32'(keep_o),      32'd0);
        chk("mr.first", 32'(first_o),     32'd0);
        chk("mr.last",  32'(last_o),      32'd0);
        chk("mr.rdy",   32'(len_ready_o), 32'd1);
        step(1'b0, 1'b0, 16'd0, 1'b1); beat("mr.n1", 4'b1111, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b1);
        chk("mr.end", 32'(valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
